// File: rtl/quiz_round_ctrl_if.sv
// Board-side bundle for quiz_round_ctrl: buzzer/answer inputs and question/score/LED outputs.
// master drives buzzers and answers (board/bench); slave is the controller.
interface quiz_round_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int LED_W       = 5
);
  logic                         start;
  logic [NUM_PLAYERS-1:0]       btn_buzz;
  logic [3:0]                   ans_in;
  logic                         ans_valid;
  logic [3:0]                   ans_key;
  logic [3:0]                   q_idx;
  logic [2:0]                   state;
  logic [2:0]                   owner;
  logic                         owner_valid;
  logic [4*NUM_PLAYERS-1:0]     score_flat;
  logic [LED_W*NUM_PLAYERS-1:0] led_flat;
  logic [2:0]                   winner;
  logic                         beep;

  modport master (
    output start, btn_buzz, ans_in, ans_valid, ans_key,
    input  q_idx, state, owner, owner_valid, score_flat, led_flat, winner, beep
  );

  modport slave (
    input  start, btn_buzz, ans_in, ans_valid, ans_key,
    output q_idx, state, owner, owner_valid, score_flat, led_flat, winner, beep
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: buzzer arbitration, answer judging, saturating per-player scores, LED bars.
// Optional macro PENALTY_EN: wrong or timed-out answers decrement the owner's score (floored at 0).
module quiz_score_lane #(
  parameter int WIN_SCORE = 5,
  parameter int LED_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [3:0]       score,
  output logic [3:0]       score_nxt,
  output logic [LED_W-1:0] led
);
  logic [LED_W-1:0] bar;

  always_comb begin
    score_nxt = score;
    if (clr)                                      score_nxt = '0;
    else if (inc && score != 4'(WIN_SCORE))       score_nxt = score + 4'd1;
    else if (dec && score != 4'd0)                score_nxt = score - 4'd1;
  end

  // Thermometer of the registered score, so the bar trails the score by a cycle.
  always_comb begin
    bar = '0;
    for (int i = 0; i < LED_W; i++) bar[i] = (32'(score) > 32'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score <= '0;
      led   <= '0;
    end else begin
      score <= score_nxt;
      led   <= bar;
    end
  end
endmodule

module quiz_round_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_QUESTIONS = 10,
  parameter int WIN_SCORE     = 5,
  parameter int LED_W         = 5,
  parameter int ANS_TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  quiz_round_ctrl_if.slave  bus
);
  localparam int CW = $clog2(ANS_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    ANSWER = 3'd2,
    JUDGE  = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } st_e;

  typedef struct packed {
    logic [3:0] val;
    logic       ok;   // cleared on timeout: forces a mismatch in JUDGE
  } cap_t;

  typedef struct packed {
    logic sc_clr;
    logic q_clr;
    logic q_adv;
    logic ld_owner;
    logic cnt_inc;
    logic cap_ld;
    logic cap_to;
    logic clr_beep;
  } ctl_t;

  st_e                              st, st_nxt;
  ctl_t                             ctl;
  logic [NUM_PLAYERS-1:0]           buzz_prev, buzz_rise;
  logic                             start_prev, start_rise;
  logic [CW-1:0]                    cnt;
  cap_t                             cap;
  logic [2:0]                       owner, own_sel, winner;
  logic                             owner_valid, beep;
  logic [3:0]                       q_idx;
  logic                             judge, correct, win_hit;
  logic [NUM_PLAYERS-1:0]           inc, dec;
  logic [NUM_PLAYERS-1:0][3:0]      score, score_nxt;
  logic [NUM_PLAYERS-1:0][LED_W-1:0] led;

  assign buzz_rise  = bus.btn_buzz & ~buzz_prev;
  assign start_rise = bus.start & ~start_prev;
  assign judge      = (st == JUDGE);
  assign correct    = cap.ok && (cap.val == bus.ans_key);

  // Lowest index wins among simultaneous buzz edges.
  always_comb begin
    own_sel = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--)
      if (buzz_rise[p]) own_sel = 3'(p);
  end

  always_comb begin
    win_hit = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (owner == 3'(p) && score_nxt[p] == 4'(WIN_SCORE)) win_hit = 1'b1;
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PLAYERS; gp++) begin : g_lane
      assign inc[gp] = judge && correct && (owner == 3'(gp));
`ifdef PENALTY_EN
      assign dec[gp] = judge && !correct && (owner == 3'(gp));
`else
      assign dec[gp] = 1'b0;
`endif
      quiz_score_lane #(
        .WIN_SCORE (WIN_SCORE),
        .LED_W     (LED_W)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clr       (ctl.sc_clr),
        .inc       (inc[gp]),
        .dec       (dec[gp]),
        .score     (score[gp]),
        .score_nxt (score_nxt[gp]),
        .led       (led[gp])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    ctl    = '0;
    case (st)
      IDLE: if (start_rise) begin
        st_nxt     = SHOW;
        ctl.sc_clr = 1'b1;
        ctl.q_clr  = 1'b1;
      end
      SHOW: if (|buzz_rise) begin
        st_nxt       = ANSWER;
        ctl.ld_owner = 1'b1;
      end
      ANSWER: begin
        if (bus.ans_valid) begin
          st_nxt     = JUDGE;
          ctl.cap_ld = 1'b1;
        end else if (cnt == CW'(ANS_TIMEOUT - 1)) begin
          st_nxt     = JUDGE;
          ctl.cap_to = 1'b1;
        end else begin
          ctl.cnt_inc = 1'b1;
        end
      end
      JUDGE:  st_nxt = win_hit ? DONE : NEXT;
      NEXT: begin
        st_nxt    = SHOW;
        ctl.q_adv = 1'b1;
      end
      DONE: if (start_rise) begin
        st_nxt       = SHOW;
        ctl.sc_clr   = 1'b1;
        ctl.q_clr    = 1'b1;
        ctl.clr_beep = 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buzz_prev   <= '0;
      start_prev  <= 1'b0;
      cnt         <= '0;
      cap         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      q_idx       <= '0;
      winner      <= '0;
      beep        <= 1'b0;
    end else begin
      buzz_prev  <= bus.btn_buzz;
      start_prev <= bus.start;
      if (ctl.ld_owner) begin
        owner       <= own_sel;
        owner_valid <= 1'b1;
        cnt         <= '0;
      end
      if (ctl.cnt_inc) cnt <= cnt + 1'b1;
      if (ctl.cap_ld) begin
        cap         <= '{val: bus.ans_in, ok: 1'b1};
        owner_valid <= 1'b0;
      end
      if (ctl.cap_to) begin
        cap         <= '{val: 4'd0, ok: 1'b0};
        owner_valid <= 1'b0;
      end
      if (ctl.q_clr)      q_idx <= '0;
      else if (ctl.q_adv) q_idx <= (q_idx == 4'(NUM_QUESTIONS - 1)) ? 4'd0 : q_idx + 4'd1;
      if (judge && win_hit) begin
        winner <= owner;
        beep   <= 1'b1;
      end
      if (ctl.clr_beep) beep <= 1'b0;
    end
  end

  assign bus.q_idx       = q_idx;
  assign bus.state       = st;
  assign bus.owner       = owner;
  assign bus.owner_valid = owner_valid;
  assign bus.score_flat  = score;
  assign bus.led_flat    = led;
  assign bus.winner      = winner;
  assign bus.beep        = beep;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: table of question rounds against a score model, judged results
// checked through a scoreboard queue, plus hand sequences for reset, win and restart.
module tb_quiz_round_ctrl;
  localparam int NP  = 2;
  localparam int NQ  = 10;
  localparam int WIN = 5;
  localparam int LW  = 5;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quiz_round_ctrl_if #(.NUM_PLAYERS(NP), .LED_W(LW)) bus ();

  quiz_round_ctrl #(
    .NUM_PLAYERS   (NP),
    .NUM_QUESTIONS (NQ),
    .WIN_SCORE     (WIN),
    .LED_W         (LW),
    .ANS_TIMEOUT   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4*NP-1:0] score;
    logic [2:0]      st;
  } sb_t;

  typedef struct {
    logic [NP-1:0] buzz;
    logic [3:0]    ans;
    logic [3:0]    key;
    bit            tmo;
    bit            rebuzz;
    logic [2:0]    own;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   sc[NP];
  int   q_m;
  sb_t  sbq[$];
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*NP-1:0] sc_flat();
    logic [4*NP-1:0] r;
    for (int p = 0; p < NP; p++) r[4*p +: 4] = 4'(sc[p]);
    return r;
  endfunction

  function automatic logic [LW*NP-1:0] led_model();
    logic [LW*NP-1:0] r;
    for (int p = 0; p < NP; p++) r[LW*p +: LW] = LW'((1 << sc[p]) - 1);
    return r;
  endfunction

  task automatic model_judge(input int p, input bit ok, output logic [2:0] es);
    sb_t e;
    if (ok) begin
      if (sc[p] < WIN) sc[p]++;
    end else begin
`ifdef PENALTY_EN
      if (sc[p] > 0) sc[p]--;
`endif
    end
    es = (sc[p] == WIN) ? 3'd5 : 3'd4;
    e.score = sc_flat();
    e.st    = es;
    sbq.push_back(e);
  endtask

  // Judged results appear on the cycle after JUDGE.
  logic [2:0] mon_prev = 3'd0;
  sb_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 3'd0;
    end else begin
      if (mon_prev == 3'd3) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_judge: got judge result with empty queue, required none");
        end else begin
          mon_e = sbq.pop_front();
          check("sb_score", 32'(bus.score_flat), 32'(mon_e.score));
          check("sb_state", 32'(bus.state), 32'(mon_e.st));
        end
      end
      mon_prev = bus.state;
    end
  end

  task automatic do_round(input vec_t v, input int idx);
    int              n;
    logic [2:0]      es;
    logic [4*NP-1:0] old;
    bus.ans_key = v.key;
    check($sformatf("r%0d_show", idx), 32'(bus.state), 32'd1);
    bus.btn_buzz = v.buzz;
    tick;
    bus.btn_buzz = '0;
    check($sformatf("r%0d_owner", idx), 32'(bus.owner), 32'(v.own));
    check($sformatf("r%0d_owner_valid", idx), 32'(bus.owner_valid), 32'd1);
    if (v.rebuzz) begin
      tick;
      bus.btn_buzz = '1;
      tick;
      bus.btn_buzz = '0;
      check($sformatf("r%0d_rebuzz_owner", idx), 32'(bus.owner), 32'(v.own));
      check($sformatf("r%0d_rebuzz_state", idx), 32'(bus.state), 32'd2);
    end
    if (v.tmo) begin
      model_judge(int'(v.own), 1'b0, es);
      n = 0;
      while (bus.state == 3'd2 && n < 1000) begin
        n++;
        tick;
      end
      check($sformatf("r%0d_timeout_cycles", idx), 32'(n), 32'(TO));
    end else begin
      old = sc_flat();
      bus.ans_in    = v.ans;
      bus.ans_valid = 1'b1;
      model_judge(int'(v.own), v.ans == v.key, es);
      tick;
      bus.ans_valid = 1'b0;
      check($sformatf("r%0d_judge_state", idx), 32'(bus.state), 32'd3);
      check($sformatf("r%0d_judge_score_hold", idx), 32'(bus.score_flat), 32'(old));
    end
    n = 0;
    while (bus.state != 3'd1 && bus.state != 3'd5 && n < 10) begin
      n++;
      tick;
    end
    check($sformatf("r%0d_end_state", idx), 32'(bus.state), (es == 3'd5) ? 32'd5 : 32'd1);
    if (es == 3'd4) begin
      q_m = (q_m == NQ - 1) ? 0 : q_m + 1;
      check($sformatf("r%0d_led", idx), 32'(bus.led_flat), 32'(led_model()));
    end
    check($sformatf("r%0d_q_idx", idx), 32'(bus.q_idx), 32'(q_m));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},       32'(bus.state), 32'd0);
    check({tag, "_q_idx"},       32'(bus.q_idx), 32'd0);
    check({tag, "_score"},       32'(bus.score_flat), 32'd0);
    check({tag, "_led"},         32'(bus.led_flat), 32'd0);
    check({tag, "_owner"},       32'(bus.owner), 32'd0);
    check({tag, "_owner_valid"}, 32'(bus.owner_valid), 32'd0);
    check({tag, "_winner"},      32'(bus.winner), 32'd0);
    check({tag, "_beep"},        32'(bus.beep), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bus.start     = 1'b0;
    bus.btn_buzz  = '0;
    bus.ans_in    = '0;
    bus.ans_valid = 1'b0;
    bus.ans_key   = '0;
    for (int p = 0; p < NP; p++) sc[p] = 0;
    q_m = 0;

    //          buzz   ans   key   tmo   rebuzz own
    vt[0] = '{2'b10, 4'd3, 4'd3, 1'b0, 1'b0, 3'd1};
    vt[1] = '{2'b11, 4'd5, 4'd5, 1'b0, 1'b1, 3'd0};
    vt[2] = '{2'b10, 4'd8, 4'd8, 1'b0, 1'b0, 3'd1};
    vt[3] = '{2'b10, 4'd0, 4'd0, 1'b1, 1'b0, 3'd1};
    vt[4] = '{2'b01, 4'd2, 4'd7, 1'b0, 1'b0, 3'd0};
    vt[5] = '{2'b01, 4'd0, 4'd0, 1'b1, 1'b0, 3'd0};
    vt[6] = '{2'b10, 4'd1, 4'd2, 1'b0, 1'b0, 3'd1};
    vt[7] = '{2'b01, 4'd0, 4'd9, 1'b0, 1'b0, 3'd0};
    vt[8] = '{2'b10, 4'd9, 4'd9, 1'b0, 1'b0, 3'd1};
    vt[9] = '{2'b01, 4'd6, 4'd5, 1'b0, 1'b0, 3'd0};

    rst = 1'b1;
    repeat (3) tick;
    check_reset_vals("rst");
    rst = 1'b0;
    tick;
    check("idle_hold", 32'(bus.state), 32'd0);

    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("start_show", 32'(bus.state), 32'd1);
    check("start_q_idx", 32'(bus.q_idx), 32'd0);
    check("start_beep", 32'(bus.beep), 32'd0);
    tick;

    // An answer strobe while showing a question must be ignored.
    bus.ans_key   = 4'd3;
    bus.ans_in    = 4'd3;
    bus.ans_valid = 1'b1;
    tick;
    bus.ans_valid = 1'b0;
    check("show_ans_ignored_state", 32'(bus.state), 32'd1);
    check("show_ans_ignored_score", 32'(bus.score_flat), 32'd0);

    for (int i = 0; i < 10; i++) do_round(vt[i], i);
    check("wrap_q_idx", 32'(bus.q_idx), 32'd0);

    // Reset mid-answer aborts the game.
    bus.btn_buzz = 2'b01;
    tick;
    bus.btn_buzz = '0;
    check("pre_rst_answer", 32'(bus.state), 32'd2);
    rst = 1'b1;
    tick;
    check_reset_vals("midrst");
    rst = 1'b0;
    for (int p = 0; p < NP; p++) sc[p] = 0;
    q_m = 0;
    tick;

    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("restart_show", 32'(bus.state), 32'd1);
    tick;

    for (int k = 0; k < WIN; k++) begin
      v = '{2'b01, 4'(k + 1), 4'(k + 1), 1'b0, 1'b0, 3'd0};
      do_round(v, 20 + k);
    end
    check("done_beep", 32'(bus.beep), 32'd1);
    check("done_winner", 32'(bus.winner), 32'd0);
    check("done_owner_valid", 32'(bus.owner_valid), 32'd0);
    tick;
    check("done_led_p0", 32'(bus.led_flat[LW-1:0]), 32'h1f);
    check("done_led_all", 32'(bus.led_flat), 32'(led_model()));

    // Scores stay frozen in DONE.
    bus.btn_buzz  = '1;
    bus.ans_in    = bus.ans_key;
    bus.ans_valid = 1'b1;
    tick;
    bus.btn_buzz  = '0;
    bus.ans_valid = 1'b0;
    tick;
    check("frozen_state", 32'(bus.state), 32'd5);
    check("frozen_score", 32'(bus.score_flat), 32'(sc_flat()));
    check("frozen_owner_valid", 32'(bus.owner_valid), 32'd0);

    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int p = 0; p < NP; p++) sc[p] = 0;
    check("newgame_state", 32'(bus.state), 32'd1);
    check("newgame_score", 32'(bus.score_flat), 32'(sc_flat()));
    check("newgame_beep", 32'(bus.beep), 32'd0);
    check("newgame_q_idx", 32'(bus.q_idx), 32'd0);
    tick;
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Clocked, parametrised successor to the question/score logic. Sequences quiz questions and arbitrates N player buzzers. Checks each player's submitted answer against the answer key and keeps saturating per-player scores. Drives question index, LED score bars and beep for the board top level; the question content table stays external, indexed by q_idx.

Parameters:
NUM_PLAYERS, 2, number of buzzer channels (1..8)
NUM_QUESTIONS, 10, questions per cycle; q_idx wraps after NUM_QUESTIONS-1
WIN_SCORE, 5, score that ends the game (1..15)
LED_W, 5, thermometer bar width per player (>= WIN_SCORE)
ANS_TIMEOUT, 255, cycles allowed in ANSWER before forced wrong (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  level; rising edge starts game from IDLE or DONE
btn_buzz  in  NUM_PLAYERS  raw buzzer levels, pre-synchronised, one bit per player
ans_in  in  4  BCD answer from the locked player
ans_valid  in  1  1-cycle strobe, ans_in valid
ans_key  in  4  correct answer for current q_idx (external table, combinational)
q_idx  out  4  current question index (bcd_state)
state  out  3  FSM state code, debug
owner  out  3  index of player holding the buzz lock
owner_valid  out  1  lock held (ANSWER state)
score_flat  out  4*NUM_PLAYERS  player p score at [4p+3:4p]
led_flat  out  LED_W*NUM_PLAYERS  thermometer bars, player p at [LED_W*p +: LED_W]
winner  out  3  index of first player at WIN_SCORE
beep  out  1  high in DONE

Behaviour:
- Reset: synchronous, all flops cleared. state=IDLE(0), q_idx=0, scores=0, led=0, owner=0, owner_valid=0, winner=0, beep=0, and buzz/start edge registers cleared. Reset asserted mid-game aborts the game immediately.
- Edge detect: btn_buzz and start registered each cycle; an event is a rising edge (cur & ~prev). Held buttons count once.
- States: IDLE=0, SHOW=1, ANSWER=2, JUDGE=3, NEXT=4, DONE=5.
- IDLE: start edge -> SHOW; scores cleared, q_idx=0.
- SHOW: any buzz edge -> ANSWER next cycle. owner is the lowest index among simultaneous edges. owner_valid=1 and the timeout counter loads 0.
- ANSWER: other players' buzzes are ignored. On ans_valid, ans_in is captured and the FSM goes to JUDGE. If the counter reaches ANS_TIMEOUT before ans_valid, go to JUDGE with a forced mismatch. ans_valid and timeout in the same cycle: ans_valid wins.
- JUDGE (1 cycle): if captured == ans_key, score[owner] += 1, saturating at WIN_SCORE. Otherwise the wrong-answer rule applies (see Optional Feature). owner_valid drops. If the updated score == WIN_SCORE, set winner=owner and go to DONE; else go to NEXT.
- NEXT (1 cycle): q_idx = (q_idx == NUM_QUESTIONS-1) ? 0 : q_idx+1. Go to SHOW.
- DONE: beep=1 and scores frozen. start edge -> clear scores, q_idx=0, beep=0, go to SHOW.
- ans_valid outside ANSWER is ignored. Buzz edges outside SHOW are ignored and not queued.
- LED bars are registered from scores: bar = (1<<score)-1, clipped to LED_W bits. Bars lag the score register by 1 cycle.
- Latency: buzz edge at cycle t (registered input) -> owner_valid at t+1. ans_valid at t -> score update visible at t+2.

Optional Feature:
PENALTY_EN
- Defined: a wrong or timed-out answer decrements score[owner], floored at 0.
- Undefined: a wrong or timed-out answer leaves the score unchanged.
- Both builds: the question still advances after a wrong answer.

Test Plan:
- Reset then start edge -> state=SHOW, q_idx=0, all score_flat=0, beep=0.
- SHOW, p1 buzz edge, ans_valid with ans_in=3, ans_key=3 -> owner=1, score p1=1, led p1=00001, q_idx=1.
- p0 and p1 buzz in the same cycle -> owner=0. p1 buzzes again during ANSWER -> owner stays 0.
- Lock held, no ans_valid for 255 cycles -> JUDGE, q_idx advances. Score unchanged without PENALTY_EN; p at score 2 drops to 1 with it; at score 0 stays 0.
- p0 answers correctly 5 times -> winner=0, beep=1, state=DONE, led p0=11111. Further buzzes change nothing; start edge resets to SHOW with scores 0.
- Run 10 questions without a winner -> q_idx 9 wraps to 0. rst asserted during ANSWER -> next cycle IDLE with all outputs at reset values.
